// File: rtl/secuenciador_notas_if.sv
// Control/status bundle of the note sequencer: beat reference, start/stop/dir
// controls from the host, tone and progress outputs back to it.
interface secuenciador_notas_if;
    logic       beat_in;
    logic       start;
    logic       stop;
    logic       dir;
    logic       tone_out;
    logic [2:0] note_idx;
    logic       busy;
    logic       done;

    modport master (
        output beat_in, start, stop, dir,
        input  tone_out, note_idx, busy, done
    );

    modport slave (
        input  beat_in, start, stop, dir,
        output tone_out, note_idx, busy, done
    );
endinterface

// File: rtl/secuenciador_notas.sv
// Melody sequencer: steps an 8-note C4..C5 scale on each beat_in rising edge and
// emits a square wave at the current note. SECUENCIA_LOOP_EN makes playback wrap.
//
// state | meaning
// IDLE  | waiting for start, outputs held at 0
// PLAY  | tone running, note advances on beat events
// FIN   | one-cycle done pulse after the last note
module secuenciador_notas #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int NUM_NOTES = 8,
    parameter int CNT_W     = 20
) (
    input  logic                 clock_in,
    input  logic                 reset_n,
    secuenciador_notas_if.slave  bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_PLAY, ST_FIN} state_t;

    localparam logic [2:0]       LAST_IDX = 3'(NUM_NOTES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = 1;

    function automatic logic [CNT_W-1:0] half_lim(input logic [2:0] i);
        int f;
        case (i)
            3'd0:    f = 262;
            3'd1:    f = 294;
            3'd2:    f = 330;
            3'd3:    f = 349;
            3'd4:    f = 392;
            3'd5:    f = 440;
            3'd6:    f = 494;
            default: f = 523;
        endcase
        return CNT_W'(CLK_FREQ / (2 * f) - 1);
    endfunction

    state_t           state, state_nx;
    logic             sync1, sync2, beat_prev;
    logic             beat_evt, at_last;
    logic             dir_q, tone_q;
    logic [2:0]       idx_q;
    logic [CNT_W-1:0] tone_cnt;

    assign beat_evt = sync2 & ~beat_prev;
    assign at_last  = (idx_q == (dir_q ? LAST_IDX : 3'd0));

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            beat_prev <= 1'b0;
        end else begin
            sync1     <= bus.beat_in;
            sync2     <= sync1;
            beat_prev <= sync2;
        end
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (bus.start) state_nx = ST_PLAY;
            ST_PLAY: begin
                if (bus.stop) state_nx = ST_IDLE;
`ifndef SECUENCIA_LOOP_EN
                else if (beat_evt && at_last) state_nx = ST_FIN;
`endif
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            dir_q    <= 1'b0;
            tone_q   <= 1'b0;
            idx_q    <= 3'd0;
            tone_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        dir_q    <= bus.dir;
                        idx_q    <= bus.dir ? 3'd0 : LAST_IDX;
                        tone_q   <= 1'b0;
                        tone_cnt <= '0;
                    end
                end
                ST_PLAY: begin
                    if (bus.stop) begin
                        tone_q   <= 1'b0;
                        idx_q    <= 3'd0;
                        tone_cnt <= '0;
                    end else if (beat_evt) begin
                        // tone level is carried across note changes; only the count restarts
                        tone_cnt <= '0;
                        if (!at_last) begin
                            idx_q <= dir_q ? idx_q + 3'd1 : idx_q - 3'd1;
                        end else begin
`ifdef SECUENCIA_LOOP_EN
                            idx_q <= dir_q ? 3'd0 : LAST_IDX;
`else
                            idx_q  <= 3'd0;
                            tone_q <= 1'b0;
`endif
                        end
                    end else if (tone_cnt == half_lim(idx_q)) begin
                        tone_q   <= ~tone_q;
                        tone_cnt <= '0;
                    end else begin
                        tone_cnt <= tone_cnt + CNT_ONE;
                    end
                end
                default: begin
                    tone_q   <= 1'b0;
                    idx_q    <= 3'd0;
                    tone_cnt <= '0;
                end
            endcase
        end
    end

    // Outputs are decoded from state so an async reset clears them without a clock.
    always_comb begin
        bus.busy     = 1'b0;
        bus.done     = 1'b0;
        bus.tone_out = 1'b0;
        bus.note_idx = 3'd0;
        case (state)
            ST_PLAY: begin
                bus.busy     = 1'b1;
                bus.tone_out = tone_q;
                bus.note_idx = idx_q;
            end
            ST_FIN:  bus.done = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_secuenciador_notas.sv
// Randomized self-checking bench for secuenciador_notas against an event-level
// note/tone model; honours SECUENCIA_LOOP_EN when the design is built with it.
module tb_secuenciador_notas;
    localparam int CLK_FREQ = 52400;
`ifdef SECUENCIA_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    logic clock_in = 1'b0;
    logic reset_n  = 1'b0;
    secuenciador_notas_if bus ();

    secuenciador_notas #(.CLK_FREQ(CLK_FREQ), .NUM_NOTES(8), .CNT_W(20)) dut (
        .clock_in (clock_in),
        .reset_n  (reset_n),
        .bus      (bus)
    );

    always #5 clock_in = ~clock_in;

    int n_checks = 0;
    int n_errors = 0;
    int freq [8] = '{262, 294, 330, 349, 392, 440, 494, 523};

    // model: note index and tone phase are derived from elapsed cycles since the note began
    bit m_play, m_fin, m_dir, b_prev, ev_h0, ev_h1;
    int m_idx, m_base, m_nstart;
    int cyc = 0;
    int done_cnt = 0, tog_cnt = 0, first_tog = -1;
    logic tone_prev = 1'b0;

    task automatic chk_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic int half_of(int i);
        return CLK_FREQ / (2 * freq[i]);
    endfunction

    function automatic int lvl(int k);
        return m_base ^ (((k - m_nstart) / half_of(m_idx)) & 1);
    endfunction

    function automatic logic [31:0] exp_vec();
        logic [2:0] ix;
        ix = m_play ? 3'(m_idx) : 3'd0;
        return {26'd0, m_play, m_fin, ix, (m_play ? lvl(cyc) : 0) != 0};
    endfunction

    task automatic model_reset();
        m_play = 0; m_fin = 0; b_prev = 0; ev_h0 = 0; ev_h1 = 0;
        m_idx = 0; m_base = 0; m_nstart = 0;
    endtask

    task automatic model_edge();
        bit rise, ev;
        if (!reset_n) begin
            model_reset();
            return;
        end
        rise = bus.beat_in & ~b_prev;
        b_prev = bus.beat_in;
        ev = ev_h1; ev_h1 = ev_h0; ev_h0 = rise;
        if (m_fin) m_fin = 0;
        else if (!m_play) begin
            if (bus.start) begin
                m_play = 1; m_dir = bus.dir; m_idx = bus.dir ? 0 : 7;
                m_base = 0; m_nstart = cyc;
            end
        end else if (bus.stop) m_play = 0;
        else if (ev) begin
            if (m_idx == (m_dir ? 7 : 0)) begin
                if (LOOP) begin
                    m_base = lvl(cyc - 1); m_idx = m_dir ? 0 : 7; m_nstart = cyc;
                end else begin
                    m_play = 0; m_fin = 1;
                end
            end else begin
                m_base = lvl(cyc - 1); m_idx += m_dir ? 1 : -1; m_nstart = cyc;
            end
        end
    endtask

    task automatic step();
        @(posedge clock_in);
        cyc++;
        model_edge();
        @(negedge clock_in);
        if (bus.done === 1'b1) done_cnt++;
        if (bus.tone_out !== tone_prev) begin
            tog_cnt++;
            if (first_tog < 0) first_tog = cyc;
        end
        tone_prev = bus.tone_out;
        chk_val("outs", {26'd0, bus.busy, bus.done, bus.note_idx, bus.tone_out}, exp_vec());
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse_start(input bit d);
        bus.dir = d; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic beat_pulse(input int hi, input int lo);
        bus.beat_in = 1'b1; run(hi);
        bus.beat_in = 1'b0; run(lo);
    endtask

    initial begin
        int s_cyc, d0, rem;
        bus.beat_in = 0; bus.start = 0; bus.stop = 0; bus.dir = 0;
        model_reset();
        run(3);
        chk_val("rst_outs", {bus.busy, bus.done, bus.note_idx, bus.tone_out}, 6'd0);
        reset_n = 1'b1;
        run(2);

        // ascending start, no beats: 100-cycle half period on C4
        pulse_start(1'b1);
        s_cyc = cyc; tog_cnt = 0; first_tog = -1;
        run(400);
        chk_val("t1_toggles", tog_cnt, 4);
        chk_val("t1_first_toggle", first_tog - s_cyc, 100);
        chk_val("t1_idx", bus.note_idx, 0);

        // first beat: note changes on the third edge
        d0 = done_cnt;
        bus.beat_in = 1'b1;
        step(); step();
        chk_val("lat_e2", bus.note_idx, 0);
        step();
        chk_val("lat_e3", bus.note_idx, 1);
        run(2);
        bus.beat_in = 1'b0; run(150);
        for (int i = 0; i < 7; i++) beat_pulse(4, 150);
        chk_val("t2_done_cnt", done_cnt - d0, LOOP ? 0 : 1);
        bus.stop = 1'b1; step(); bus.stop = 1'b0;
        run(5);

        // descending run
        d0 = done_cnt;
        pulse_start(1'b0);
        chk_val("t3_first_idx", bus.note_idx, 7);
        for (int i = 0; i < 8; i++) beat_pulse($urandom_range(3, 8), $urandom_range(20, 130));
        chk_val("t3_done_cnt", done_cnt - d0, LOOP ? 0 : 1);
        bus.stop = 1'b1; step(); bus.stop = 1'b0;
        run(5);

        // stop coinciding with a beat event at idx 3; start while playing is ignored
        d0 = done_cnt;
        pulse_start(1'b1);
        for (int i = 0; i < 3; i++) beat_pulse(3, 20);
        pulse_start(1'b0);
        chk_val("t4_start_ignored", bus.note_idx, 3);
        bus.beat_in = 1'b1;
        step(); step();
        bus.stop = 1'b1; step(); bus.stop = 1'b0;
        chk_val("t4_stop_busy", bus.busy, 0);
        chk_val("t4_stop_idx", bus.note_idx, 0);
        chk_val("t4_no_done", done_cnt - d0, 0);
        bus.beat_in = 1'b0; run(10);

        // async reset mid-play at idx 4
        pulse_start(1'b1);
        for (int i = 0; i < 4; i++) beat_pulse(3, 25);
        chk_val("t5_pre_idx", bus.note_idx, 4);
        #2 reset_n = 1'b0;
        model_reset();
        #1 chk_val("t5_async", {bus.busy, bus.done, bus.note_idx, bus.tone_out}, 6'd0);
        run(3);
        reset_n = 1'b1;
        for (int i = 0; i < 2; i++) beat_pulse(3, 10);
        chk_val("t5_idle_busy", bus.busy, 0);

        if (LOOP) begin
            d0 = done_cnt;
            pulse_start(1'b1);
            for (int i = 0; i < 24; i++) beat_pulse(3, $urandom_range(5, 40));
            chk_val("t6_busy", bus.busy, 1);
            chk_val("t6_idx", bus.note_idx, 0);
            chk_val("t6_no_done", done_cnt - d0, 0);
            bus.stop = 1'b1; step(); bus.stop = 1'b0;
        end

        // random traffic
        rem = 5;
        for (int i = 0; i < 6000; i++) begin
            if (rem == 0) begin
                bus.beat_in = ~bus.beat_in;
                rem = $urandom_range(3, 120);
            end
            rem--;
            bus.start = ($urandom_range(0, 39) == 0);
            bus.stop  = ($urandom_range(0, 249) == 0);
            bus.dir   = 1'($urandom);
            step();
        end
        bus.start = 0; bus.stop = 0;
        run(5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
